seg_scan_drv: RTL and testbench

- Downstream consumer of the cascaded mod-10 counter digits.
- Time-multiplexes DIGITS BCD digits onto one shared 7-segment bus with one-hot anode drive.
- Double-buffered capture: new counts take effect only at a frame boundary, so the display never shows a torn value.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 54 +++++
 rtl/seg_scan_drv.sv | 107 ++++++++++
 tb/tb_seg_scan_drv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared active-low 7-segment codes ({g,f,e,d,c,b,a}) and anode helpers for the scan driver.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All-off anode pattern for n digits (active-low, so the low n bits are 1).
  function automatic logic [7:0] ANODE_OFF(input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational value-to-segment decoder; HEX_DECODE_EN selects A..F glyphs for 10..15,
// otherwise those values (and anything wider than a nibble) show a dash.
module seg7_decode
  import seg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [6:0]       code
);

`ifdef HEX_DECODE_EN
  localparam logic [6:0] HI_10 = SEG_A;
  localparam logic [6:0] HI_11 = SEG_B;
  localparam logic [6:0] HI_12 = SEG_C;
  localparam logic [6:0] HI_13 = SEG_D;
  localparam logic [6:0] HI_14 = SEG_E;
  localparam logic [6:0] HI_15 = SEG_F;
`else
  localparam logic [6:0] HI_10 = SEG_DASH;
  localparam logic [6:0] HI_11 = SEG_DASH;
  localparam logic [6:0] HI_12 = SEG_DASH;
  localparam logic [6:0] HI_13 = SEG_DASH;
  localparam logic [6:0] HI_14 = SEG_DASH;
  localparam logic [6:0] HI_15 = SEG_DASH;
`endif

  logic [31:0] v;

  always_comb begin
    v    = 32'(value);
    code = SEG_DASH;
    case (v)
      32'd0:   code = SEG_0;
      32'd1:   code = SEG_1;
      32'd2:   code = SEG_2;
      32'd3:   code = SEG_3;
      32'd4:   code = SEG_4;
      32'd5:   code = SEG_5;
      32'd6:   code = SEG_6;
      32'd7:   code = SEG_7;
      32'd8:   code = SEG_8;
      32'd9:   code = SEG_9;
      32'd10:  code = HI_10;
      32'd11:  code = HI_11;
      32'd12:  code = HI_12;
      32'd13:  code = HI_13;
      32'd14:  code = HI_14;
      32'd15:  code = HI_15;
      default: code = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed 7-segment driver with frame-boundary double-buffered capture and
// leading-zero blanking. HEX_DECODE_EN (in seg7_decode) enables A..F glyphs.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] digits_in,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic                    blank_lz,
  output logic [DIGITS-1:0]       an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0]     PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]     BLANK_END = PW'(BLANK_CYC);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF    = DIGITS'(ANODE_OFF(DIGITS));
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [DIGITS*WIDTH-1:0] shadow_dig, active_dig;
  logic [DIGITS-1:0]       shadow_dp, active_dp;
  logic                    pending;
  logic                    tick, wrap;
  logic [WIDTH-1:0]        cur_digit;
  logic [6:0]              dec_code;
  logic [DIGITS-1:0]       blank_vec;

  assign tick      = (prescaler == PRE_LAST);
  assign wrap      = tick && (idx == IDX_LAST);
  assign cur_digit = active_dig[idx*WIDTH +: WIDTH];

  seg7_decode #(.WIDTH(WIDTH)) u_decode (
    .value (cur_digit),
    .code  (dec_code)
  );

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero   = upper_zero && (active_dig[k*WIDTH +: WIDTH] == '0);
      blank_vec[k] = blank_lz && upper_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
      active_dig <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      frame_done <= wrap;

      // A load landing on the wrap cycle goes straight to the active buffer.
      if (wrap) begin
        if (load) begin
          active_dig <= digits_in;
          active_dp  <= dp_in;
        end else if (pending) begin
          active_dig <= shadow_dig;
          active_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        shadow_dig <= digits_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end

      if (prescaler < BLANK_END) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= AN_OFF & ~(AN_ONE << idx);
        seg <= blank_vec[idx] ? SEG_BLANK : dec_code;
        dp  <= ~active_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv: a frame-level reference model queues the expected
// bus state every cycle, and a monitor compares it against the DUT outputs.
module tb_seg_scan_drv;

  localparam int DIGITS      = 4;
  localparam int WIDTH       = 4;
  localparam int REFRESH_DIV = 8;
  localparam int BLANK_CYC   = 1;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_scan_drv #(
    .DIGITS(DIGITS), .WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];
  logic [12:0] got_e;

  // Reference state: cycles since reset, the frame's shown value and the queued request.
  int          t = 0;
  logic [15:0] m_dig = '0, m_sdig = '0;
  logic [3:0]  m_dp = '0, m_sdp = '0;
  bit          m_pend = 0;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
`ifdef HEX_DECODE_EN
      4'd10: return 7'h08;
      4'd11: return 7'h03;
      4'd12: return 7'h46;
      4'd13: return 7'h21;
      4'd14: return 7'h06;
      4'd15: return 7'h0E;
`endif
      default: return 7'h3F;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [12:0] e;
    int ph, sl, msd;
    e = {4'hF, 7'h7F, 1'b1, 1'b0};
    if (rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_sdig = '0; m_sdp = '0; m_pend = 0;
    end else begin
      ph  = t % REFRESH_DIV;
      sl  = (t / REFRESH_DIV) % DIGITS;
      msd = 0;
      for (int k = 0; k < DIGITS; k++) if (m_dig[k*4 +: 4] != 4'd0) msd = k;
      if (ph >= BLANK_CYC) begin
        e[12:9] = ~(4'b0001 << sl);
        e[8:2]  = (blank_lz && sl > msd) ? 7'h7F : glyph(m_dig[sl*4 +: 4]);
        e[1]    = ~m_dp[sl];
      end
      e[0] = (t % FRAME == FRAME - 1);
      if (t % FRAME == FRAME - 1) begin
        if (load) begin m_dig = digits_in; m_dp = dp_in; end
        else if (m_pend) begin m_dig = m_sdig; m_dp = m_sdp; end
        m_pend = 0;
      end else if (load) begin
        m_sdig = digits_in; m_sdp = dp_in; m_pend = 1;
      end
      t++;
    end
    exp_q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty at %0t: got an=%b seg=%h, required a queued expectation", $time, an, seg);
    end else begin
      got_e = exp_q.pop_front();
      if ({an, seg, dp, frame_done} !== got_e) begin
        fails++;
        $display("FAIL bus at %0t: got an=%b seg=%h dp=%b fd=%b, required an=%b seg=%h dp=%b fd=%b",
                 $time, an, seg, dp, frame_done, got_e[12:9], got_e[8:2], got_e[1], got_e[0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop at the negedge before the edge where the frame position equals x.
  task automatic go_to(input int x);
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      if (t % FRAME == x) return;
    end
  endtask

  task automatic pulse(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; digits_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0; digits_in = 16'($urandom); dp_in = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2 * FRAME + 4);                       // idle zeros, frame_done cadence
    go_to(10); pulse(16'h4321, 4'b0000);      // mid-frame load waits for wrap
    cyc(FRAME + 4);
    go_to(5);  pulse(16'h5678, 4'b1000);
    go_to(29); pulse(16'h9105, 4'b0001);      // last value wins
    cyc(FRAME + 2);
    go_to(31); pulse(16'h2468, 4'b0101);      // load on the wrap cycle
    cyc(FRAME + 2);
    blank_lz = 1'b1;
    go_to(31); pulse(16'h0007, 4'b0000);
    cyc(FRAME + 2);
    go_to(31); pulse(16'h0000, 4'b0100);
    cyc(FRAME + 2);
    go_to(31); pulse(16'h0308, 4'b0000);
    cyc(FRAME + 2);
    blank_lz = 1'b0;
    go_to(31); pulse(16'h00C0, 4'b0010);      // out-of-range value, dp on digit 1
    cyc(FRAME + 2);
    go_to(31); pulse(16'hFEDA, 4'b0000);
    cyc(FRAME + 2);
    go_to(17); pulse(16'h9999, 4'b1111);      // pending load, then reset in slot 2
    go_to(19);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2 * FRAME + 2);
    for (int i = 0; i < 40; i++) begin
      blank_lz = 1'($urandom);
      go_to($urandom_range(0, FRAME - 1));
      if ($urandom_range(0, 3) != 0) pulse(16'($urandom), 4'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        blank_lz = 1'b1;
        go_to(31); pulse(16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3)), 4'($urandom));
      end
    end
    cyc(FRAME + 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
